// File: rtl/fir_xifu_wb.sv
// FIR XIFU writeback stage.
// Takes one instruction at a time from the EX/WB register and waits for the
// LSU load result when the instruction needs one. It writes XIFU register-file
// destinations and returns the post-incremented base address on the
// X-interface result channel. It also drives the base-address forwarding bus
// used by the execute stage.
module fir_xifu_wb #(
  parameter int ID_WIDTH       = 4,
  parameter int RESULT_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                ex_valid_i,
  input  logic [1:0]          ex_instr_i,
  input  logic [ID_WIDTH-1:0] ex_id_i,
  input  logic [4:0]          ex_rs1_i,
  input  logic [4:0]          ex_rd_i,
  input  logic [31:0]         ex_result_i,
  output logic                ready_o,
  input  logic                mem_result_valid_i,
  input  logic [ID_WIDTH-1:0] mem_result_id_i,
  input  logic [31:0]         mem_result_rdata_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic                result_we_o,
  output logic [4:0]          result_rd_o,
  output logic [31:0]         result_data_o,
  output logic                rf_we_o,
  output logic [4:0]          rf_waddr_o,
  output logic [31:0]         rf_wdata_o,
  output logic                fwd_we_o,
  output logic [4:0]          fwd_rd_o,
  output logic [31:0]         fwd_result_o,
  output logic                protocol_err_o
);

  localparam logic [1:0] I_INVALID = 2'd0;
  localparam logic [1:0] I_LW      = 2'd1;
  localparam logic [1:0] I_SW      = 2'd2;
  localparam logic [1:0] I_DOTP    = 2'd3;
  localparam logic [7:0] TMO       = 8'(RESULT_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESULT} state_e;

  // Instruction held by the stage while it waits for memory or for the core.
  typedef struct packed {
    logic [1:0]          instr;
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rs1;
    logic [4:0]          rd;
    logic [31:0]         res;
  } entry_t;

  state_e      state_q;
  entry_t      ent_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic accept, ex_mem_hit, wait_hit, in_result, res_we;

  // Handshake and decode. ready_o depends only on the state and result_ready_i.
  always_comb begin
    ready_o    = (state_q == IDLE) | ((state_q == RESULT) & result_ready_i);
    accept     = ex_valid_i & (ex_instr_i != I_INVALID) & ready_o & ~clear_i;
    ex_mem_hit = mem_result_valid_i & (mem_result_id_i == ex_id_i);
    wait_hit   = mem_result_valid_i & (mem_result_id_i == ent_q.id);
    in_result  = (state_q == RESULT);
    res_we     = in_result & (ent_q.instr != I_DOTP);
  end

  // Result, forwarding and regfile outputs come only from registered state.
  // Result fields and forwarding outputs are zero outside RESULT.
  assign result_valid_o = in_result;
  assign result_id_o    = in_result ? ent_q.id : '0;
  assign result_we_o    = res_we;
  assign result_rd_o    = res_we ? ent_q.rs1 : 5'd0;
  assign result_data_o  = res_we ? ent_q.res : 32'd0;
  assign fwd_we_o       = res_we;
  assign fwd_rd_o       = res_we ? ent_q.rs1 : 5'd0;
  assign fwd_result_o   = res_we ? ent_q.res : 32'd0;
  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign protocol_err_o = err_q;

  // Writeback FSM: capture, memory wait, result hold, error tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ent_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      // The regfile strobe lasts a single cycle unless it is set again below.
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      if (clear_i) begin
        // A flush drops the pending instruction. The sticky error flag survives it.
        state_q <= IDLE;
        ent_q   <= '0;
        cnt_q   <= 8'd0;
      end else begin
        case (state_q)
          IDLE, RESULT: begin
            // A load result is legal here only when it hits an LW accepted in this same cycle.
            if (mem_result_valid_i && !(accept && ex_instr_i == I_LW && ex_mem_hit))
              err_q <= 1'b1;
            if (accept) begin
              ent_q <= '{ex_instr_i, ex_id_i, ex_rs1_i, ex_rd_i, ex_result_i};
              cnt_q <= 8'd0;
              case (ex_instr_i)
                I_DOTP: begin
                  state_q    <= RESULT;
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= ex_rd_i;
                  rf_wdata_q <= ex_result_i;
                end
                I_SW: state_q <= RESULT;
                default: begin
                  if (ex_mem_hit) begin
                    state_q    <= RESULT;
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= ex_rd_i;
                    rf_wdata_q <= mem_result_rdata_i;
                  end else begin
                    state_q <= WAIT_MEM;
                  end
                end
              endcase
            end else if (in_result && result_ready_i) begin
              state_q <= IDLE;
              ent_q   <= '0;
            end
          end
          WAIT_MEM: begin
            if (wait_hit) begin
              state_q    <= RESULT;
              rf_we_q    <= 1'b1;
              rf_waddr_q <= ent_q.rd;
              rf_wdata_q <= mem_result_rdata_i;
            end else begin
              // A result with the wrong id is ignored but flagged. The timeout flags the error and keeps waiting.
              if (mem_result_valid_i) err_q <= 1'b1;
              if (cnt_q == TMO) err_q <= 1'b1;
              else              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Directed, table-driven bench for the FIR XIFU writeback stage. Each record
// holds one cycle of inputs and the outputs expected in that cycle, sampled
// before the next rising edge. The outputs reflect state registered at earlier
// edges, plus ready_o, which depends combinationally on result_ready_i.
module tb_fir_xifu_wb;
  logic        clk = 1'b0;
  logic        rst, clr, ev, mv, rr;
  logic [1:0]  ins;
  logic [3:0]  id, mid;
  logic [4:0]  rs1, rd;
  logic [31:0] res, md;
  logic        rdy, rv, rwe, rfwe, fwe, err;
  logic [3:0]  rid;
  logic [4:0]  rrd, rfa, frd;
  logic [31:0] rdat, rfd, fres;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_xifu_wb #(.ID_WIDTH(4), .RESULT_TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .ex_valid_i(ev), .ex_instr_i(ins), .ex_id_i(id), .ex_rs1_i(rs1),
    .ex_rd_i(rd), .ex_result_i(res), .ready_o(rdy),
    .mem_result_valid_i(mv), .mem_result_id_i(mid), .mem_result_rdata_i(md),
    .result_valid_o(rv), .result_ready_i(rr), .result_id_o(rid),
    .result_we_o(rwe), .result_rd_o(rrd), .result_data_o(rdat),
    .rf_we_o(rfwe), .rf_waddr_o(rfa), .rf_wdata_o(rfd),
    .fwd_we_o(fwe), .fwd_rd_o(frd), .fwd_result_o(fres),
    .protocol_err_o(err)
  );

  typedef struct {
    logic rst, clr, ev; logic [1:0] ins; logic [3:0] id; logic [4:0] rs1, rd;
    logic [31:0] res; logic mv; logic [3:0] mid; logic [31:0] md; logic rr;
    logic x_rdy, x_rv; logic [3:0] x_rid; logic x_rwe; logic [4:0] x_rrd;
    logic [31:0] x_rdat; logic x_rfwe; logic [4:0] x_rfa; logic [31:0] x_rfd;
    logic x_err;
  } vec_t;

  vec_t vq[$];
  vec_t cur;

  task automatic vin(input logic a_rst, a_clr, a_ev, input logic [1:0] a_ins,
                     input logic [3:0] a_id, input logic [4:0] a_rs1, a_rd,
                     input logic [31:0] a_res, input logic a_mv,
                     input logic [3:0] a_mid, input logic [31:0] a_md, input logic a_rr);
    cur.rst = a_rst; cur.clr = a_clr; cur.ev = a_ev; cur.ins = a_ins; cur.id = a_id;
    cur.rs1 = a_rs1; cur.rd = a_rd; cur.res = a_res; cur.mv = a_mv; cur.mid = a_mid;
    cur.md = a_md; cur.rr = a_rr;
  endtask

  task automatic vexp(input logic e_rdy, e_rv, input logic [3:0] e_rid, input logic e_rwe,
                      input logic [4:0] e_rrd, input logic [31:0] e_rdat, input logic e_rfwe,
                      input logic [4:0] e_rfa, input logic [31:0] e_rfd, input logic e_err);
    cur.x_rdy = e_rdy; cur.x_rv = e_rv; cur.x_rid = e_rid; cur.x_rwe = e_rwe;
    cur.x_rrd = e_rrd; cur.x_rdat = e_rdat; cur.x_rfwe = e_rfwe; cur.x_rfa = e_rfa;
    cur.x_rfd = e_rfd; cur.x_err = e_err;
    vq.push_back(cur);
  endtask

  task automatic idle_in(input logic a_rr);
    vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a_rr);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; clr = v.clr; ev = v.ev; ins = v.ins; id = v.id; rs1 = v.rs1;
    rd = v.rd; res = v.res; mv = v.mv; mid = v.mid; md = v.md; rr = v.rr;
  endtask

  initial begin
    vec_t z;
    z = '{default: '0};
    drive(z);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---- vector table: inputs, then expected outputs for that cycle ----
    idle_in(1);                                vexp(1,0,0,0,0,0,0,0,0,0);           // 0 reset state
    vin(0,0,1,3,2,0,5,'h1234,0,0,0,1);         vexp(1,0,0,0,0,0,0,0,0,0);           // 1 DOTP id2
    vin(0,0,1,3,3,0,6,'h55,0,0,0,1);           vexp(1,1,2,0,0,0,1,5,'h1234,0);      // 2 back-to-back DOTP
    idle_in(1);                                vexp(1,1,3,0,0,0,1,6,'h55,0);        // 3
    vin(0,0,1,1,1,10,3,'h1004,0,0,0,1);        vexp(1,0,0,0,0,0,0,0,0,0);           // 4 LW id1
    idle_in(1);                                vexp(0,0,0,0,0,0,0,0,0,0);           // 5 WAIT_MEM
    idle_in(1);                                vexp(0,0,0,0,0,0,0,0,0,0);           // 6
    vin(0,0,0,0,0,0,0,0,1,1,'hDEADBEEF,1);     vexp(0,0,0,0,0,0,0,0,0,0);           // 7 mem result
    idle_in(1);                                vexp(1,1,1,1,10,'h1004,1,3,'hDEADBEEF,0); // 8
    vin(0,0,1,2,4,7,0,'h2000,0,0,0,1);         vexp(1,0,0,0,0,0,0,0,0,0);           // 9 SW id4
    for (int k = 0; k < 4; k++) begin                                               // 10-13 stall
      vin(0,0,1,3,5,0,1,'h99,0,0,0,0);         vexp(0,1,4,1,7,'h2000,0,0,0,0);
    end
    vin(0,0,1,3,5,0,1,'h99,0,0,0,1);           vexp(1,1,4,1,7,'h2000,0,0,0,0);      // 14 handshake+accept
    idle_in(1);                                vexp(1,1,5,0,0,0,1,1,'h99,0);        // 15
    vin(0,0,1,1,1,2,4,'h3000,0,0,0,1);         vexp(1,0,0,0,0,0,0,0,0,0);           // 16 LW id1
    vin(0,0,0,0,0,0,0,0,1,6,'h11,1);           vexp(0,0,0,0,0,0,0,0,0,0);           // 17 wrong id
    idle_in(1);                                vexp(0,0,0,0,0,0,0,0,0,1);           // 18 error set
    vin(0,0,0,0,0,0,0,0,1,1,'hCAFE,1);         vexp(0,0,0,0,0,0,0,0,0,1);           // 19 right id
    idle_in(1);                                vexp(1,1,1,1,2,'h3000,1,4,'hCAFE,1); // 20
    vin(0,0,1,1,2,3,5,'h40,0,0,0,1);           vexp(1,0,0,0,0,0,0,0,0,1);           // 21 LW id2
    vin(0,1,0,0,0,0,0,0,0,0,0,1);              vexp(0,0,0,0,0,0,0,0,0,1);           // 22 clear in WAIT_MEM
    idle_in(1);                                vexp(1,0,0,0,0,0,0,0,0,1);           // 23 back to IDLE
    vin(0,0,1,2,7,9,0,'h50,0,0,0,0);           vexp(1,0,0,0,0,0,0,0,0,1);           // 24 SW id7
    vin(1,0,0,0,0,0,0,0,0,0,0,0);              vexp(0,1,7,1,9,'h50,0,0,0,1);        // 25 reset in RESULT
    idle_in(1);                                vexp(1,0,0,0,0,0,0,0,0,0);           // 26 after reset
    vin(0,0,1,1,3,4,8,'h60,1,3,'h77,1);        vexp(1,0,0,0,0,0,0,0,0,0);           // 27 LW same-cycle hit
    idle_in(1);                                vexp(1,1,3,1,4,'h60,1,8,'h77,0);     // 28
    vin(0,0,1,0,0,0,0,0,0,0,0,1);              vexp(1,0,0,0,0,0,0,0,0,0);           // 29 INVALID bubble
    idle_in(1);                                vexp(1,0,0,0,0,0,0,0,0,0);           // 30 still IDLE
    vin(0,0,0,0,0,0,0,0,1,2,'h5,1);            vexp(1,0,0,0,0,0,0,0,0,0);           // 31 mem in IDLE
    idle_in(1);                                vexp(1,0,0,0,0,0,0,0,0,1);           // 32 error set

    foreach (vq[i]) begin
      logic xf;
      @(negedge clk);
      drive(vq[i]);
      #1;
      xf = vq[i].x_rv & vq[i].x_rwe;
      chk($sformatf("v%0d.ready", i), 64'(rdy), 64'(vq[i].x_rdy));
      chk($sformatf("v%0d.result", i), {21'd0, rv, rid, rwe, rrd, rdat},
          {21'd0, vq[i].x_rv, vq[i].x_rid, vq[i].x_rwe, vq[i].x_rrd, vq[i].x_rdat});
      chk($sformatf("v%0d.rf", i), {26'd0, rfwe, rfa, rfd},
          {26'd0, vq[i].x_rfwe, vq[i].x_rfa, vq[i].x_rfd});
      chk($sformatf("v%0d.fwd", i), {26'd0, fwe, frd, fres},
          {26'd0, xf, xf ? vq[i].x_rrd : 5'd0, xf ? vq[i].x_rdat : 32'd0});
      chk($sformatf("v%0d.err", i), 64'(err), 64'(vq[i].x_err));
    end

    // ---- hand sequence: WAIT_MEM timeout raises the error, state is kept ----
    @(negedge clk); drive(z); rst = 1'b1;
    @(negedge clk); drive(z); ev = 1'b1; ins = 2'd1; id = 4'd9; rs1 = 5'd1; rd = 5'd2;
    res = 32'h10; rr = 1'b1;
    for (int k = 0; k <= 262; k++) begin
      @(negedge clk); drive(z); rr = 1'b1;
      #1;
      if (k == 0)   chk("tmo.enter_wait", {63'd0, rdy}, 64'd0);
      if (k == 250) chk("tmo.no_err_early", {62'd0, rdy, err}, 64'd0);
      if (k == 262) chk("tmo.err_set_still_waiting", {62'd0, rdy, err}, 64'd1);
    end
    // A late matching result still completes normally after the timeout.
    @(negedge clk); drive(z); mv = 1'b1; mid = 4'd9; md = 32'hAB; rr = 1'b1;
    @(negedge clk); drive(z); rr = 1'b1;
    #1;
    chk("tmo.late_complete", {23'd0, rv, rwe, rrd, rfwe, rfa, rfd, err},
        {23'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 32'hAB, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
